// File: rtl/pixel_pkg.sv
// Shared types and constants for the pixel memory write path.
// Provides the pixel coordinate/colour typedefs, the packed draw request
// carried through the draw FIFO, the panel geometry constants and the
// scheduler state encoding.
package pixel_pkg;

    localparam int PANEL_W    = 64;
    localparam int PANEL_H    = 64;
    localparam int NUM_PIXELS = PANEL_W * PANEL_H;

    typedef logic [5:0] pixel_coord_t;
    typedef logic [2:0] pixel_color_t;

    typedef struct packed {
        pixel_coord_t x;
        pixel_coord_t y;
        pixel_color_t color;
    } draw_req_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DRAIN = 2'd2
    } sched_state_t;

endpackage

// File: rtl/draw_req_fifo.sv
// Synchronous FIFO of draw requests between the renderer and the scheduler.
// Ports:
//   clk, rst_n   : clock and asynchronous active-low reset
//   push         : write request (ignored while full)
//   push_data    : request written on an accepted push
//   pop          : read request (ignored while empty)
//   pop_data     : current head entry (valid while not empty)
//   count        : number of stored entries, 0..QDEPTH
//   full, empty  : derived from the registered count
module draw_req_fifo
    import pixel_pkg::*;
#(
    parameter int QDEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  draw_req_t                  push_data,
    input  logic                       pop,
    output draw_req_t                  pop_data,
    output logic [$clog2(QDEPTH):0]    count,
    output logic                       full,
    output logic                       empty
);
    localparam int PTR_W = $clog2(QDEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;
    draw_req_t        mem_q [QDEPTH];

    assign full     = (count_q == (PTR_W+1)'(QDEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // Pointers wrap naturally because QDEPTH is a power of two; a push and
    // a pop in the same cycle leave the count unchanged.
    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, do_pop};
        count_d  = count_q + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once counted as valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/pixel_write_scheduler.sv
// Sole owner of the pixel memory write port. Arbitrates between full-frame
// clear sweeps and queued single-pixel draws, issuing writes only when the
// scan driver flags the following cycle as free (write_window).
// Ports:
//   clk, rst_n                   : clock, asynchronous active-low reset
//   clear_req / clear_color      : clear request pulse and fill colour
//   clear_busy / clear_done      : sweep pending-or-running, last-write pulse
//   draw_valid/ready/x/y/color   : draw request handshake into the FIFO
//   write_window                 : port free in the next cycle
//   mem_write_en/x/y/color       : registered pixel memory write port
module pixel_write_scheduler
    import pixel_pkg::*;
#(
    parameter int QDEPTH = 4,
    parameter int CNT_W  = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear_req,
    input  pixel_color_t clear_color,
    output logic         clear_busy,
    output logic         clear_done,
    input  logic         draw_valid,
    output logic         draw_ready,
    input  pixel_coord_t draw_x,
    input  pixel_coord_t draw_y,
    input  pixel_color_t draw_color,
    input  logic         write_window,
    output logic         mem_write_en,
    output pixel_coord_t mem_write_x,
    output pixel_coord_t mem_write_y,
    output pixel_color_t mem_write_color
);
    localparam int               FCNT_W   = $clog2(QDEPTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PIXELS - 1);

    sched_state_t      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              clear_pending_q, clear_pending_d;
    pixel_color_t      clear_color_q, clear_color_d;
    pixel_color_t      shadow_color_q, shadow_color_d;
    logic              clear_busy_q, clear_busy_d;
    logic              mem_write_en_q, mem_write_en_d;
    pixel_coord_t      mem_write_x_q, mem_write_x_d;
    pixel_coord_t      mem_write_y_q, mem_write_y_d;
    pixel_color_t      mem_write_color_q, mem_write_color_d;

    logic              clear_fire, drain_fire;
    logic              fifo_full, fifo_empty;
    logic [FCNT_W-1:0] fifo_count;
    draw_req_t         fifo_in, fifo_head;

    assign fifo_in = '{x: draw_x, y: draw_y, color: draw_color};

    draw_req_fifo #(.QDEPTH(QDEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (draw_valid),
        .push_data (fifo_in),
        .pop       (drain_fire),
        .pop_data  (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. A clear request that cannot start a sweep right away
    // (sweep in progress, or draining) is parked in clear_pending with its
    // colour in the shadow register; IDLE then launches it. A fresh request
    // seen in IDLE wins over a parked one since it carries the newer colour.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        clear_pending_d = clear_pending_q;
        clear_color_d   = clear_color_q;
        shadow_color_d  = shadow_color_q;
        case (state_q)
            ST_IDLE: begin
                if (clear_req) begin
                    state_d         = ST_CLEAR;
                    clear_color_d   = clear_color;
                    clear_pending_d = 1'b0;
                end else if (clear_pending_q) begin
                    state_d         = ST_CLEAR;
                    clear_color_d   = shadow_color_q;
                    clear_pending_d = 1'b0;
                end else if (!fifo_empty) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_CLEAR: begin
                if (clear_req) begin
                    clear_pending_d = 1'b1;
                    shadow_color_d  = clear_color;
                end
                if (clear_fire) begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (clear_req) begin
                    clear_pending_d = 1'b1;
                    shadow_color_d  = clear_color;
                end
                if (clear_req || clear_pending_q || fifo_empty ||
                    (drain_fire && fifo_count == FCNT_W'(1))) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        clear_busy_d = (state_d == ST_CLEAR) | clear_pending_d;
    end

    // Output logic: write decisions for this cycle and the next value of the
    // registered memory port. Address/colour hold when no write is issued.
    always_comb begin
        clear_fire        = (state_q == ST_CLEAR) && write_window;
        drain_fire        = (state_q == ST_DRAIN) && write_window && !fifo_empty;
        clear_done        = clear_fire && (cnt_q == LAST_CNT);
        mem_write_en_d    = clear_fire | drain_fire;
        mem_write_x_d     = mem_write_x_q;
        mem_write_y_d     = mem_write_y_q;
        mem_write_color_d = mem_write_color_q;
        if (clear_fire) begin
            mem_write_x_d     = cnt_q[5:0];
            mem_write_y_d     = cnt_q[11:6];
            mem_write_color_d = clear_color_q;
        end else if (drain_fire) begin
            mem_write_x_d     = fifo_head.x;
            mem_write_y_d     = fifo_head.y;
            mem_write_color_d = fifo_head.color;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q             <= '0;
            clear_pending_q   <= 1'b0;
            clear_color_q     <= '0;
            shadow_color_q    <= '0;
            clear_busy_q      <= 1'b0;
            mem_write_en_q    <= 1'b0;
            mem_write_x_q     <= '0;
            mem_write_y_q     <= '0;
            mem_write_color_q <= '0;
        end else begin
            cnt_q             <= cnt_d;
            clear_pending_q   <= clear_pending_d;
            clear_color_q     <= clear_color_d;
            shadow_color_q    <= shadow_color_d;
            clear_busy_q      <= clear_busy_d;
            mem_write_en_q    <= mem_write_en_d;
            mem_write_x_q     <= mem_write_x_d;
            mem_write_y_q     <= mem_write_y_d;
            mem_write_color_q <= mem_write_color_d;
        end
    end

    assign clear_busy      = clear_busy_q;
    assign draw_ready      = ~fifo_full;
    assign mem_write_en    = mem_write_en_q;
    assign mem_write_x     = mem_write_x_q;
    assign mem_write_y     = mem_write_y_q;
    assign mem_write_color = mem_write_color_q;

endmodule
